// File: rtl/ov7670_capture_if.sv
// Frame-buffer write port driven by the OV7670 capture block.
// The master drives the buffer and the slave (the frame buffer) receives.
interface ov7670_capture_if #(
  parameter int c_nb_img_pxls = 13,
  parameter int c_nb_buf      = 12
);
  logic [c_nb_img_pxls-1:0] frame_addr;
  logic [c_nb_buf-1:0]      frame_pixel;
  logic                     frame_we;
  logic                     frame_done;

  modport master (output frame_addr, frame_pixel, frame_we, frame_done);
  modport slave  (input  frame_addr, frame_pixel, frame_we, frame_done);
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 capture: brings the camera bus into clk, decimates the QQVGA stream by 2
// in both axes and writes 12-bit pixels (RGB444 or luminance) into the frame buffer.
module ov7670_capture #(
  parameter int c_cam_cols    = 160,
  parameter int c_cam_rows    = 120,
  parameter int c_img_cols    = 80,
  parameter int c_img_rows    = 60,
  parameter int c_img_pxls    = c_img_cols * c_img_rows,
  parameter int c_nb_img_pxls = 13,
  parameter int c_nb_buf      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ov7670_pclk,
  input  logic             ov7670_href,
  input  logic             ov7670_vsync,
  input  logic [7:0]       ov7670_d,
  input  logic             rgbmode,
  ov7670_capture_if.master fb
);
  localparam int CW = $clog2(c_cam_cols + 1);
  localparam int RW = $clog2(c_cam_rows + 1);
  localparam logic [CW-1:0]            COL_END   = CW'(c_cam_cols);
  localparam logic [RW-1:0]            ROW_END   = RW'(c_cam_rows);
  localparam logic [c_nb_img_pxls-1:0] ADDR_LAST = c_nb_img_pxls'(c_img_pxls - 1);

  typedef enum logic {S_WAIT_VS, S_CAPTURE} state_t;
  state_t state_q, state_d;

  logic [2:0] ctl_p0_q, ctl_p1_q, ctl_p2_q;  // {pclk, href, vsync}
  logic [7:0] d_p0_q, d_p1_q, byte_p3_q;
  logic       pclk_re_p3_q, href_p3_q, href_fe_p3_q, vs_re_p3_q, vs_fe_p3_q;

  logic                     mode_q, mode_d, phase_q, phase_d, full_q, full_d;
  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic [7:0]               byte_hi_q, byte_hi_d;
  logic [c_nb_img_pxls-1:0] frame_addr_q, frame_addr_d;
  logic [c_nb_buf-1:0]      frame_pixel_q, frame_pixel_d;
  logic                     frame_we_q, frame_we_d, frame_done_q, frame_done_d;

  logic pclk_re, href_fe, vs_re, vs_fe;
  assign pclk_re =  ctl_p1_q[2] & ~ctl_p2_q[2];
  assign href_fe = ~ctl_p1_q[1] &  ctl_p2_q[1];
  assign vs_re   =  ctl_p1_q[0] & ~ctl_p2_q[0];
  assign vs_fe   = ~ctl_p1_q[0] &  ctl_p2_q[0];

  // stages p0/p1 synchronise, p2 keeps the previous synced level, p3 registers the edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_p0_q     <= '0;
      ctl_p1_q     <= '0;
      ctl_p2_q     <= '0;
      pclk_re_p3_q <= 1'b0;
      href_p3_q    <= 1'b0;
      href_fe_p3_q <= 1'b0;
      vs_re_p3_q   <= 1'b0;
      vs_fe_p3_q   <= 1'b0;
    end else begin
      ctl_p0_q     <= {ov7670_pclk, ov7670_href, ov7670_vsync};
      ctl_p1_q     <= ctl_p0_q;
      ctl_p2_q     <= ctl_p1_q;
      pclk_re_p3_q <= pclk_re;
      href_p3_q    <= ctl_p1_q[1];
      href_fe_p3_q <= href_fe;
      vs_re_p3_q   <= vs_re;
      vs_fe_p3_q   <= vs_fe;
    end
  end

  always_ff @(posedge clk) begin
    d_p0_q    <= ov7670_d;
    d_p1_q    <= d_p0_q;
    byte_p3_q <= d_p1_q;
    byte_hi_q <= byte_hi_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_WAIT_VS;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_VS: if (vs_fe_p3_q) state_d = S_CAPTURE;
      S_CAPTURE: if (vs_re_p3_q) state_d = S_WAIT_VS;
      default:   state_d = S_WAIT_VS;
    endcase
  end

  always_comb begin
    mode_d        = mode_q;
    phase_d       = phase_q;
    full_d        = full_q;
    col_d         = col_q;
    row_d         = row_q;
    byte_hi_d     = byte_hi_q;
    frame_addr_d  = frame_addr_q;
    frame_pixel_d = frame_pixel_q;
    frame_we_d    = 1'b0;
    frame_done_d  = 1'b0;
    // the address advances the cycle after a write and sticks at the last word
    if (frame_we_q) begin
      if (frame_addr_q == ADDR_LAST) full_d = 1'b1;
      else                           frame_addr_d = frame_addr_q + 1'b1;
    end
    case (state_q)
      S_WAIT_VS: begin
        if (vs_fe_p3_q) begin
          mode_d       = rgbmode;
          phase_d      = 1'b0;
          col_d        = '0;
          row_d        = '0;
          full_d       = 1'b0;
          frame_addr_d = '0;
        end
      end
      S_CAPTURE: begin
        if (vs_re_p3_q) begin
          frame_done_d = 1'b1;
        end else if (href_fe_p3_q) begin
          col_d   = '0;
          phase_d = 1'b0;
          if (row_q != ROW_END) row_d = row_q + 1'b1;
        end else if (pclk_re_p3_q && href_p3_q) begin
          if (!phase_q) begin
            byte_hi_d = byte_p3_q;
            phase_d   = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (col_q != COL_END) col_d = col_q + 1'b1;
            if (!col_q[0] && !row_q[0] && col_q < COL_END && row_q < ROW_END && !full_q) begin
              frame_we_d    = 1'b1;
              frame_pixel_d = mode_q ? c_nb_buf'({byte_hi_q[3:0], byte_p3_q})
                                     : c_nb_buf'({4'b0000, byte_hi_q});
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q        <= 1'b0;
      phase_q       <= 1'b0;
      full_q        <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      frame_addr_q  <= '0;
      frame_pixel_q <= '0;
      frame_we_q    <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      phase_q       <= phase_d;
      full_q        <= full_d;
      col_q         <= col_d;
      row_q         <= row_d;
      frame_addr_q  <= frame_addr_d;
      frame_pixel_q <= frame_pixel_d;
      frame_we_q    <= frame_we_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign fb.frame_addr  = frame_addr_q;
  assign fb.frame_pixel = frame_pixel_q;
  assign fb.frame_we    = frame_we_q;
  assign fb.frame_done  = frame_done_q;
endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture: drives scaled-down camera frames (16x12 -> 8x6) and
// compares every buffer write against a raster-order reference model.
`timescale 1ns/10ps
module tb_ov7670_capture;
  localparam int CC  = 16;
  localparam int CR  = 12;
  localparam int IC  = 8;
  localparam int IR  = 6;
  localparam int NPX = IC * IR;
  localparam int AW  = 13;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] hi;
    logic [7:0] lo;
  } px_t;

  logic       clk = 1'b0, rst = 1'b1, pclk = 1'b0, href = 1'b0, vsync = 1'b1, rgbmode = 1'b1;
  logic [7:0] d = 8'h00;

  int errors = 0;
  int checks = 0;
  int done_cycles = 0;
  int wr_addr_q[$];
  int wr_pix_q[$];
  px_t sent_q[$];
  logic [11:0] exp_q[$];

  ov7670_capture_if #(.c_nb_img_pxls(AW), .c_nb_buf(12)) fb ();

  ov7670_capture #(
    .c_cam_cols(CC), .c_cam_rows(CR), .c_img_cols(IC), .c_img_rows(IR),
    .c_nb_img_pxls(AW), .c_nb_buf(12)
  ) dut (
    .clk(clk), .rst(rst), .ov7670_pclk(pclk), .ov7670_href(href),
    .ov7670_vsync(vsync), .ov7670_d(d), .rgbmode(rgbmode), .fb(fb)
  );

  always #5 clk = ~clk;
  initial begin
    #1.3;
    forever #25.25 pclk = ~pclk;
  end

  always @(negedge clk) begin
    if (fb.frame_we === 1'b1) begin
      wr_addr_q.push_back(int'(fb.frame_addr));
      wr_pix_q.push_back(int'(fb.frame_pixel));
    end
    if (fb.frame_done === 1'b1) done_cycles++;
  end

  function automatic logic [7:0] gen_byte(input int pat, input int r, input int c, input bit second);
    logic [3:0] rn;
    rn = 4'($urandom);
    case (pat)
      0:       return second ? 8'hBC : 8'h0A;
      1:       return second ? 8'(c) : {rn, 4'(r)};
      2:       return (c % 2 == 0) ? (second ? 8'h11 : 8'hC8) : (second ? 8'h22 : 8'h37);
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_pix_q.delete();
    done_cycles = 0;
  endtask

  // Bytes change on the falling pclk edge; the camera samples on the rising one.
  task automatic send_frame(input int cols, input int rows, input int pat, input int cut_r, input int cut_c);
    logic [7:0] hi, lo;
    bit stop;
    stop = 1'b0;
    sent_q.delete();
    @(negedge pclk);
    vsync = 1'b1;
    href  = 1'b0;
    repeat (4) @(negedge pclk);
    vsync = 1'b0;
    repeat (4) @(negedge pclk);
    for (int r = 0; r < rows && !stop; r++) begin
      href = 1'b1;
      for (int c = 0; c < cols && !stop; c++) begin
        hi = gen_byte(pat, r, c, 1'b0);
        d  = hi;
        @(negedge pclk);
        lo = gen_byte(pat, r, c, 1'b1);
        d  = lo;
        if (r == cut_r && c == cut_c) begin
          @(posedge pclk);
          vsync = 1'b1;
          stop  = 1'b1;
        end else begin
          sent_q.push_back({8'(r), 8'(c), hi, lo});
        end
        @(negedge pclk);
      end
      href = 1'b0;
      repeat (3) @(negedge pclk);
    end
    vsync = 1'b1;
    repeat (6) @(negedge pclk);
    repeat (4) @(negedge clk);
  endtask

  // Reference: keep even rows/cols inside the camera size, in raster order, up to one frame.
  task automatic build_model(input bit mode);
    px_t p;
    exp_q.delete();
    foreach (sent_q[i]) begin
      p = sent_q[i];
      if (p.row[0] == 1'b0 && p.col[0] == 1'b0 && int'(p.row) < CR && int'(p.col) < CC
          && exp_q.size() < NPX)
        exp_q.push_back(mode ? {p.hi[3:0], p.lo} : {4'h0, p.hi});
    end
  endtask

  task automatic test_reset();
    rgbmode = 1'b1;
    rst = 1'b1;
    clear_mon();
    fork
      send_frame(CC, CR, 3, -1, -1);
      begin
        repeat (700) @(negedge clk);
        checks++;
        if (fb.frame_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b expected 0", fb.frame_we); end
        checks++;
        if (fb.frame_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", fb.frame_addr); end
        checks++;
        if (fb.frame_pixel !== '0) begin errors++; $display("FAIL reset_pixel: got %0h expected 0", fb.frame_pixel); end
        checks++;
        if (fb.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", fb.frame_done); end
      end
    join
    checks++;
    if (wr_addr_q.size() !== 0) begin errors++; $display("FAIL reset_writes: got %0d expected 0", wr_addr_q.size()); end
    clear_mon();
    fork
      send_frame(CC, CR, 3, -1, -1);
      begin
        repeat (500) @(posedge clk);
        rst = 1'b0;
      end
    join
    checks++;
    if (wr_addr_q.size() !== 0) begin errors++; $display("FAIL midframe_writes: got %0d expected 0", wr_addr_q.size()); end
    checks++;
    if (done_cycles !== 0) begin errors++; $display("FAIL midframe_done: got %0d expected 0", done_cycles); end
  endtask

  task automatic test_rgb_const();
    rgbmode = 1'b1;
    clear_mon();
    send_frame(CC, CR, 0, -1, -1);
    checks++;
    if (wr_pix_q.size() !== NPX) begin errors++; $display("FAIL rgb_count: got %0d expected %0d", wr_pix_q.size(), NPX); end
    foreach (wr_pix_q[i]) begin
      checks++;
      if (wr_addr_q[i] !== i) begin errors++; $display("FAIL rgb_addr[%0d]: got %0d expected %0d", i, wr_addr_q[i], i); end
      checks++;
      if (wr_pix_q[i] !== 'hABC) begin errors++; $display("FAIL rgb_pixel[%0d]: got %0h expected abc", i, wr_pix_q[i]); end
    end
    checks++;
    if (done_cycles !== 1) begin errors++; $display("FAIL rgb_done: got %0d cycles expected 1", done_cycles); end
    checks++;
    if (int'(fb.frame_addr) !== NPX - 1) begin errors++; $display("FAIL rgb_addr_hold: got %0d expected %0d", fb.frame_addr, NPX - 1); end
  endtask

  task automatic test_decimation();
    int exp_v;
    rgbmode = 1'b1;
    clear_mon();
    send_frame(CC, CR, 1, -1, -1);
    checks++;
    if (wr_pix_q.size() !== NPX) begin errors++; $display("FAIL dec_count: got %0d expected %0d", wr_pix_q.size(), NPX); end
    for (int a = 0; a < NPX && a < wr_pix_q.size(); a++) begin
      exp_v = ((2 * (a / IC)) % 16) * 256 + 2 * (a % IC);
      checks++;
      if (wr_addr_q[a] !== a) begin errors++; $display("FAIL dec_addr[%0d]: got %0d expected %0d", a, wr_addr_q[a], a); end
      checks++;
      if (wr_pix_q[a] !== exp_v) begin errors++; $display("FAIL dec_pixel[%0d]: got %0h expected %0h", a, wr_pix_q[a], exp_v); end
    end
  endtask

  task automatic test_yuv();
    rgbmode = 1'b0;
    clear_mon();
    fork
      send_frame(CC, CR, 2, -1, -1);
      begin
        repeat (1200) @(posedge clk);
        rgbmode = 1'b1;
      end
    join
    build_model(1'b0);
    checks++;
    if (wr_pix_q.size() !== exp_q.size()) begin errors++; $display("FAIL yuv_count: got %0d expected %0d", wr_pix_q.size(), exp_q.size()); end
    checks++;
    if (wr_pix_q.size() == 0 || wr_pix_q[0] !== 'h0C8) begin errors++; $display("FAIL yuv_first: got %0h expected 0c8", (wr_pix_q.size() > 0) ? wr_pix_q[0] : -1); end
    foreach (exp_q[i]) if (i < wr_pix_q.size()) begin
      checks++;
      if (wr_pix_q[i] !== int'(exp_q[i])) begin errors++; $display("FAIL yuv_pixel[%0d]: got %0h expected %0h", i, wr_pix_q[i], exp_q[i]); end
    end
    clear_mon();
    send_frame(CC, CR, 0, -1, -1);
    checks++;
    if (wr_pix_q.size() !== NPX) begin errors++; $display("FAIL yuv_next_count: got %0d expected %0d", wr_pix_q.size(), NPX); end
    checks++;
    if (wr_pix_q.size() == 0 || wr_pix_q[NPX/2] !== 'hABC) begin errors++; $display("FAIL yuv_next_mode: got %0h expected abc", (wr_pix_q.size() > NPX/2) ? wr_pix_q[NPX/2] : -1); end
  endtask

  task automatic test_oversize();
    rgbmode = 1'b1;
    clear_mon();
    send_frame(CC + 4, CR + 3, 3, -1, -1);
    build_model(1'b1);
    checks++;
    if (wr_pix_q.size() !== NPX) begin errors++; $display("FAIL over_count: got %0d expected %0d", wr_pix_q.size(), NPX); end
    foreach (exp_q[i]) if (i < wr_pix_q.size()) begin
      checks++;
      if (wr_addr_q[i] !== i) begin errors++; $display("FAIL over_addr[%0d]: got %0d expected %0d", i, wr_addr_q[i], i); end
      checks++;
      if (wr_pix_q[i] !== int'(exp_q[i])) begin errors++; $display("FAIL over_pixel[%0d]: got %0h expected %0h", i, wr_pix_q[i], exp_q[i]); end
    end
    checks++;
    if (int'(fb.frame_addr) !== NPX - 1) begin errors++; $display("FAIL over_addr_hold: got %0d expected %0d", fb.frame_addr, NPX - 1); end
  endtask

  task automatic test_vs_collision();
    rgbmode = 1'b1;
    clear_mon();
    send_frame(CC, CR, 3, 4, 6);
    build_model(1'b1);
    checks++;
    if (wr_pix_q.size() !== 2 * IC + 3) begin errors++; $display("FAIL vs_cut_count: got %0d expected %0d", wr_pix_q.size(), 2 * IC + 3); end
    foreach (exp_q[i]) if (i < wr_pix_q.size()) begin
      checks++;
      if (wr_pix_q[i] !== int'(exp_q[i])) begin errors++; $display("FAIL vs_cut_pixel[%0d]: got %0h expected %0h", i, wr_pix_q[i], exp_q[i]); end
    end
    checks++;
    if (done_cycles !== 1) begin errors++; $display("FAIL vs_cut_done: got %0d cycles expected 1", done_cycles); end
    clear_mon();
    send_frame(CC, CR, 0, -1, -1);
    checks++;
    if (wr_addr_q.size() == 0 || wr_addr_q[0] !== 0) begin errors++; $display("FAIL vs_restart_addr: got %0d expected 0", (wr_addr_q.size() > 0) ? wr_addr_q[0] : -1); end
    checks++;
    if (wr_addr_q.size() !== NPX) begin errors++; $display("FAIL vs_restart_count: got %0d expected %0d", wr_addr_q.size(), NPX); end
  endtask

  task automatic test_random();
    int cols, rows;
    bit mode;
    for (int f = 0; f < 2; f++) begin
      cols = CC - 3 + $urandom_range(0, 6);
      rows = CR - 3 + $urandom_range(0, 6);
      mode = 1'($urandom);
      rgbmode = mode;
      clear_mon();
      send_frame(cols, rows, 3, -1, -1);
      build_model(mode);
      checks++;
      if (wr_pix_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", wr_pix_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < wr_pix_q.size()) begin
        checks++;
        if (wr_addr_q[i] !== i) begin errors++; $display("FAIL rand_addr[%0d]: got %0d expected %0d", i, wr_addr_q[i], i); end
        checks++;
        if (wr_pix_q[i] !== int'(exp_q[i])) begin errors++; $display("FAIL rand_pixel[%0d]: got %0h expected %0h", i, wr_pix_q[i], exp_q[i]); end
      end
      checks++;
      if (done_cycles !== 1) begin errors++; $display("FAIL rand_done: got %0d cycles expected 1", done_cycles); end
    end
  endtask

  initial begin
    test_reset();
    test_rgb_const();
    test_decimation();
    test_yuv();
    test_oversize();
    test_vs_collision();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
- Writer side of the 80x60 frame buffer: captures pixels from the OV7670 camera and writes them into the buffer that the VGA display path reads.
- Samples the camera's pclk/href/vsync/data in the FPGA clock domain.
- Decimates the camera's 160x120 (QQVGA) stream by 2 in both axes to 80x60.
- Packs each pixel into the 12-bit buffer word: RGB444, or luminance in YUV mode.

Parameters:
- c_cam_cols, 160, camera pixels per line (must be 2*c_img_cols)
- c_cam_rows, 120, camera lines per frame (must be 2*c_img_rows)
- c_img_cols, 80, stored pixels per line
- c_img_rows, 60, stored lines per frame
- c_img_pxls, c_img_cols*c_img_rows, stored pixels per frame (4800)
- c_nb_img_pxls, 13, frame address width
- c_nb_buf, 12, buffer word width (4 red + 4 green + 4 blue)

Ports:
- rst  in  1  reset, asynchronous, active high
- clk  in  1  FPGA clock; frequency must be at least 4x ov7670_pclk
- ov7670_pclk  in  1  camera pixel clock (asynchronous to clk)
- ov7670_href  in  1  line valid, active high
- ov7670_vsync  in  1  frame sync, high during vertical blanking
- ov7670_d  in  8  camera data byte
- rgbmode  in  1  1: RGB444 (xR,GB byte pairs); 0: YUYV
- frame_addr  out  c_nb_img_pxls  buffer write address
- frame_pixel  out  c_nb_buf  buffer write data
- frame_we  out  1  buffer write enable, one clk pulse per stored pixel
- frame_done  out  1  one clk pulse when a frame completes

Behaviour:
- Reset values: frame_addr=0, frame_pixel=0, frame_we=0, frame_done=0. State=S_WAIT_VS. All counters and the phase bit cleared. Reset mid-frame drops the frame and resumes at the next vsync falling edge.
- Synchronisation:
  - pclk, href, vsync and d pass through 2-FF synchronisers.
  - A third pclk FF detects the synced rising edge (pclk_re). vsync and href edges are detected the same way.
  - On pclk_re, the synced data byte is the captured byte.
- State machine:
  - S_WAIT_VS -> S_CAPTURE on synced vsync falling edge. rgbmode is latched at this edge (mode_r); it is constant for the whole frame.
  - S_CAPTURE -> S_WAIT_VS on synced vsync rising edge. frame_done pulses for 1 clk on this transition.
  - Entering S_CAPTURE clears cam_col, cam_row, the phase bit and frame_addr.
- Byte handling (S_CAPTURE, pclk_re with href=1):
  - phase=0: latch byte into byte_hi; phase<=1.
  - phase=1: form pixel; phase<=0; cam_col<=cam_col+1 (saturating at c_cam_cols).
  - Pixel format when mode_r=1: {byte_hi[3:0], byte} (R, G, B).
  - Pixel format when mode_r=0: {4'b0000, byte_hi} (Y of the first byte of each pair; the display shows bits [7:4] as grey).
- Line handling: on synced href falling edge: cam_col<=0, phase<=0, cam_row<=cam_row+1 (saturating at c_cam_rows).
- Decimation/write rule: at pixel formation, write only if all of the following hold:
  - cam_col[0]=0 and cam_row[0]=0
  - cam_col<c_cam_cols and cam_row<c_cam_rows
  - frame_addr has not passed c_img_pxls-1
- Write timing: frame_pixel and frame_addr are valid in the same clk cycle that frame_we=1. frame_addr increments by 1 in the cycle after each write.
- Address boundary: after the write at address c_img_pxls-1 (4799), frame_addr holds at 4799 and no further writes occur in that frame.
- Writes occur only in S_CAPTURE with href=1. Bytes with href=0 are ignored.
- Simultaneous events: if a vsync rising edge coincides with pclk_re, the vsync edge wins and no write occurs. If an href falling edge coincides with pclk_re, the byte is discarded.
- Extra lines or extra pixels beyond the camera size are ignored, with no address wrap.
- Latency: frame_we asserts 4 clk cycles after the pclk edge that carried the second byte (2 sync + 1 edge + 1 output register).

Test Plan:
- Reset held, camera toggling -> frame_we=0, frame_addr=0, frame_done=0. Release mid-frame -> no writes until the next vsync falling edge.
- One RGB frame, 160x120, pixel bytes (0x0A,0xBC) everywhere, rgbmode=1 -> exactly 4800 frame_we pulses; addresses 0..4799 in order; every frame_pixel=0xABC; one frame_done.
- Decimation: camera pixel value = {row[3:0], col[7:0]} -> stored word at address a equals the camera pixel at row 2*(a/80), col 2*(a%80). Odd rows and columns are never written.
- YUV mode: bytes Y=0xC8, U=0x11, Y=0x37, V=0x22 repeating, rgbmode=0 -> even stored pixels=0x0C8. rgbmode toggled mid-frame has no effect until the next frame.
- Oversized frame (170 px x 130 lines) -> still 4800 writes; frame_addr holds at 4799; no write beyond it.
- vsync rising edge in the same clk as pclk_re -> no write that cycle; frame_done=1 for exactly one clk; the next frame restarts at address 0.
